// File: rtl/mc_cpu.sv
// mc_cpu: multi-cycle, non-pipelined R-type CPU.
// IDLE -> FETCH -> EXEC -> FETCH ... until a HALT instruction.
module mc_cpu #(
    parameter int DW  = 32,
    parameter int IAW = 8
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           run,
    output logic           imem_req,
    output logic [IAW-1:0] imem_addr,
    input  logic           imem_valid,
    input  logic [31:0]    imem_data,
    input  logic           dbg_we,
    input  logic [4:0]     dbg_waddr,
    input  logic [DW-1:0]  dbg_wdata,
    output logic [DW-1:0]  ALU_OUT,
    output logic           ALU_OF,
    output logic           ALU_ZF,
    output logic           halted,
    output logic [IAW-1:0] dbg_pc,
    output logic [1:0]     dbg_state
);

    localparam int SW = $clog2(DW);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t state, next;

    logic [IAW-1:0] pc;
    logic [31:0]    ir;
    logic [DW-1:0]  regs [32];

    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    logic [5:0] func;
    logic       is_halt;

    logic [DW-1:0] a, b, f, sum, diff;
    logic          of, legal;

    logic unused_ok;

    assign op   = ir[5:0];
    assign rs   = ir[10:6];
    assign rt   = ir[15:11];
    assign rd   = ir[20:16];
    assign func = ir[31:26];

    assign unused_ok = ^ir[25:21];

    assign is_halt = (op == 6'h3F);

    assign a = (rs == 5'd0) ? '0 : regs[rs];
    assign b = (rt == 5'd0) ? '0 : regs[rt];

    assign sum  = a + b;
    assign diff = a - b;

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;
    assign halted    = (state == HALT);
    assign dbg_pc    = pc;
    assign dbg_state = state;

    // State register; reset has priority over every input.
    always_ff @(posedge CLK) begin
        if (!RST) state <= IDLE;
        else      state <= next;
    end

    // Next-state logic; HALT is absorbing until reset.
    always_comb begin
        next = state;
        unique case (state)
            IDLE:  if (run) next = FETCH;
            FETCH: if (imem_valid) next = EXEC;
            EXEC:  next = is_halt ? HALT : FETCH;
            HALT:  next = HALT;
            default: next = IDLE;
        endcase
    end

    // ALU: result, signed overflow and legality of the func code.
    always_comb begin
        f     = '0;
        of    = 1'b0;
        legal = (op == 6'h00);
        unique case (func)
            6'h20: begin
                f  = sum;
                of = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
            end
            6'h22: begin
                f  = diff;
                of = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
            end
            6'h24: f = a & b;
            6'h25: f = a | b;
            6'h26: f = a ^ b;
            6'h27: f = ~(a | b);
            6'h2A: f = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
            6'h04: f = a << b[SW-1:0];
            default: legal = 1'b0;
        endcase
    end

    // Datapath: PC, instruction latch, register file and result flags.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            pc      <= '0;
            ir      <= '0;
            ALU_OUT <= '0;
            ALU_OF  <= 1'b0;
            ALU_ZF  <= 1'b0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (dbg_we && dbg_waddr != 5'd0)
                        regs[dbg_waddr] <= dbg_wdata;
                end
                FETCH: begin
                    if (imem_valid) ir <= imem_data;
                end
                EXEC: begin
                    if (!is_halt) begin
                        pc <= pc + IAW'(4);
                        if (legal) begin
                            if (rd != 5'd0) regs[rd] <= f;
                            ALU_OUT <= f;
                            ALU_OF  <= of;
                            ALU_ZF  <= (f == '0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_cpu.sv
// tb_mc_cpu: directed table-driven bench for mc_cpu
// plus hand sequences for stalls, PC wrap, HALT and reset.
module tb_mc_cpu;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        run = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_data = '0;
    logic        dbg_we = 1'b0;
    logic [4:0]  dbg_waddr = '0;
    logic [31:0] dbg_wdata = '0;
    logic [31:0] ALU_OUT;
    logic        ALU_OF;
    logic        ALU_ZF;
    logic        halted;
    logic [7:0]  dbg_pc;
    logic [1:0]  dbg_state;

    int tests = 0;
    int fails = 0;

    mc_cpu #(.DW(32), .IAW(8)) dut (
        .CLK(CLK), .RST(RST), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data),
        .dbg_we(dbg_we), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata),
        .ALU_OUT(ALU_OUT), .ALU_OF(ALU_OF), .ALU_ZF(ALU_ZF),
        .halted(halted), .dbg_pc(dbg_pc), .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic        restart;
        logic [31:0] p1;
        logic [31:0] p2;
        logic [31:0] ins;
        int          w;
        logic [31:0] out;
        logic        of;
        logic        zf;
        logic [7:0]  pc;
    } vec_t;

    vec_t tbl [18];

    function automatic logic [31:0] r(input logic [5:0] fn,
                                      input logic [4:0] rd,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt);
        return {fn, 5'd0, rd, rt, rs, 6'd0};
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0;
        run = 1'b1;
        dbg_we = 1'b1;
        dbg_waddr = 5'd1;
        dbg_wdata = 32'hDEAD;
        repeat (2) @(negedge CLK);
        check("rst_state", dbg_state, 0);
        check("rst_pc", dbg_pc, 0);
        check("rst_req", imem_req, 0);
        check("rst_flags", {ALU_OUT, ALU_OF, ALU_ZF, halted}, 0);
        RST = 1'b1;
        run = 1'b0;
        dbg_we = 1'b0;
    endtask

    task automatic preload(input logic [4:0] ad, input logic [31:0] d);
        dbg_we = 1'b1;
        dbg_waddr = ad;
        dbg_wdata = d;
        @(negedge CLK);
        dbg_we = 1'b0;
    endtask

    task automatic go();
        run = 1'b1;
        @(negedge CLK);
        run = 1'b0;
    endtask

    task automatic exec_instr(input logic [31:0] ins, input int w);
        int n;
        logic [7:0] pc0;
        n = 0;
        while (dbg_state != 2'd1 && n < 10) begin
            @(negedge CLK);
            n++;
        end
        check("fetch_reached", dbg_state, 1);
        pc0 = dbg_pc;
        for (int i = 0; i < w; i++) begin
            check("req_hold", {imem_req, imem_addr}, {1'b1, pc0});
            @(negedge CLK);
        end
        check("req_hold", {imem_req, imem_addr}, {1'b1, pc0});
        imem_valid = 1'b1;
        imem_data = ins;
        @(negedge CLK);
        imem_valid = 1'b0;
        imem_data = 32'hFFFF_FFFF;
        check("exec_state", {dbg_state, imem_req}, {2'd2, 1'b0});
        @(negedge CLK);
    endtask

    initial begin
        tbl[0]  = '{1, 32'd5, 32'd7, r(6'h20, 3, 1, 2), 0, 32'd12, 0, 0, 8'd4};
        tbl[1]  = '{0, 0, 0, r(6'h25, 4, 3, 0), 3, 32'd12, 0, 0, 8'd8};
        tbl[2]  = '{0, 0, 0, r(6'h20, 0, 1, 2), 0, 32'd12, 0, 0, 8'd12};
        tbl[3]  = '{0, 0, 0, r(6'h25, 5, 0, 0), 0, 32'd0, 0, 1, 8'd16};
        tbl[4]  = '{0, 0, 0, r(6'h21, 6, 1, 2), 0, 32'd0, 0, 1, 8'd20};
        tbl[5]  = '{0, 0, 0, r(6'h20, 7, 1, 2) | 32'd1, 0, 32'd0, 0, 1, 8'd24};
        tbl[6]  = '{0, 0, 0, r(6'h22, 6, 1, 2), 0, 32'hFFFF_FFFE, 0, 0, 8'd28};
        tbl[7]  = '{0, 0, 0, r(6'h24, 7, 1, 2), 0, 32'd5, 0, 0, 8'd32};
        tbl[8]  = '{0, 0, 0, r(6'h26, 8, 1, 2), 0, 32'd2, 0, 0, 8'd36};
        tbl[9]  = '{0, 0, 0, r(6'h27, 9, 1, 2), 0, 32'hFFFF_FFF8, 0, 0, 8'd40};
        tbl[10] = '{0, 0, 0, r(6'h2A, 10, 6, 1), 0, 32'd1, 0, 0, 8'd44};
        tbl[11] = '{0, 0, 0, r(6'h2A, 11, 1, 6), 0, 32'd0, 0, 1, 8'd48};
        tbl[12] = '{0, 0, 0, r(6'h04, 12, 1, 2), 1, 32'h280, 0, 0, 8'd52};
        tbl[13] = '{1, 32'h7FFF_FFFF, 32'd1, r(6'h20, 3, 1, 2), 0,
                    32'h8000_0000, 1, 0, 8'd4};
        tbl[14] = '{0, 0, 0, r(6'h22, 4, 1, 1), 0, 32'd0, 0, 1, 8'd8};
        tbl[15] = '{0, 0, 0, r(6'h22, 5, 3, 2), 0, 32'h7FFF_FFFF, 1, 0, 8'd12};
        tbl[16] = '{0, 0, 0, r(6'h20, 6, 3, 3), 0, 32'd0, 1, 1, 8'd16};
        tbl[17] = '{0, 0, 0, r(6'h04, 7, 1, 1), 0, 32'h8000_0000, 0, 0, 8'd20};

        RST = 1'b1;
        for (int k = 0; k < 18; k++) begin
            if (tbl[k].restart) begin
                do_reset();
                preload(5'd0, 32'd99);
                preload(5'd1, tbl[k].p1);
                preload(5'd2, tbl[k].p2);
                go();
            end
            exec_instr(tbl[k].ins, tbl[k].w);
            check($sformatf("vec%0d_out", k), ALU_OUT, tbl[k].out);
            check($sformatf("vec%0d_of_zf", k), {ALU_OF, ALU_ZF},
                  {tbl[k].of, tbl[k].zf});
            check($sformatf("vec%0d_pc", k), dbg_pc, tbl[k].pc);
        end

        // imem_valid in IDLE ignored; dbg_we in FETCH ignored; PC wrap; HALT.
        do_reset();
        imem_valid = 1'b1;
        imem_data = r(6'h20, 3, 1, 2);
        repeat (2) @(negedge CLK);
        check("idle_valid_ignored", {dbg_state, imem_req, dbg_pc}, 0);
        imem_valid = 1'b0;
        go();
        dbg_we = 1'b1;
        dbg_waddr = 5'd2;
        dbg_wdata = 32'h55;
        @(negedge CLK);
        dbg_we = 1'b0;
        exec_instr(r(6'h25, 3, 2, 0), 0);
        check("dbg_we_fetch_ignored", {ALU_OUT, ALU_ZF}, {32'd0, 1'b1});
        for (int k = 0; k < 62; k++) exec_instr(32'h0000_0001, 0);
        check("pc_before_wrap", dbg_pc, 8'hFC);
        exec_instr(32'h0000_0001, 0);
        check("pc_wrapped", dbg_pc, 8'h00);
        exec_instr(r(6'h20, 3, 1, 2) | 32'h3F, 0);
        check("halt_state", {dbg_state, halted}, {2'd3, 1'b1});
        check("halt_pc", dbg_pc, 8'h00);
        check("halt_no_flags", {ALU_OUT, ALU_OF, ALU_ZF}, {32'd0, 2'b01});
        run = 1'b1;
        imem_valid = 1'b1;
        repeat (3) @(negedge CLK);
        run = 1'b0;
        imem_valid = 1'b0;
        check("halt_sticky", {dbg_state, halted, imem_req, dbg_pc},
              {2'd3, 1'b1, 1'b0, 8'h00});

        // Reset while a fetch is pending.
        do_reset();
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd7);
        go();
        exec_instr(r(6'h20, 3, 1, 2), 0);
        check("pre_rst_out", ALU_OUT, 32'd12);
        repeat (2) @(negedge CLK);
        check("pre_rst_req", {imem_req, imem_addr}, {1'b1, 8'd4});
        RST = 1'b0;
        @(negedge CLK);
        check("midfetch_rst", {dbg_state, imem_req, dbg_pc}, 0);
        check("midfetch_rst_flags", {ALU_OUT, ALU_OF, ALU_ZF}, 0);
        RST = 1'b1;
        go();
        exec_instr(r(6'h25, 3, 1, 2), 0);
        check("regs_cleared", {ALU_OUT, ALU_ZF}, {32'd0, 1'b1});
        check("regs_cleared_pc", dbg_pc, 8'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
